// File: rtl/bit_conditioner_pkg.sv
// Shared definitions for the pin conditioner: debounce state codes, which are also exported on stout.
package bit_conditioner_pkg;
    typedef enum logic [1:0] {
        LO     = 2'b00,
        CHK_HI = 2'b01,
        HI     = 2'b10,
        CHK_LO = 2'b11
    } db_state_e;
endpackage

// File: rtl/bit_conditioner_sync_2ff.sv
// Two-flop synchroniser for asynchronous pin inputs; synchronous active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/bit_conditioner.sv
// Synchronises and debounces a raw pin into a clean level w, with one-cycle rise/fall pulses and a debug state code.
module bit_conditioner
    import bit_conditioner_pkg::*;
#(
    parameter int DB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pin,
    output logic       w,
    output logic       w_rise,
    output logic       w_fall,
    output logic [1:0] stout
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          s2;
    db_state_e     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          w_nxt, rise_nxt, fall_nxt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pin),
        .q   (s2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= LO;
            cnt    <= '0;
            w      <= 1'b0;
            w_rise <= 1'b0;
            w_fall <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            w      <= w_nxt;
            w_rise <= rise_nxt;
            w_fall <= fall_nxt;
        end
    end

    // Any opposite sample during a check drops back to the stable state; the count restarts from 0 on re-entry.
    always_comb begin
        state_nxt = LO;
        cnt_nxt   = cnt;
        w_nxt     = w;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            LO: begin
                if (s2) begin
                    state_nxt = CHK_HI;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = LO;
                end
            end
            CHK_HI: begin
                if (!s2) begin
                    state_nxt = LO;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = HI;
                    w_nxt     = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    state_nxt = CHK_HI;
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            HI: begin
                if (!s2) begin
                    state_nxt = CHK_LO;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = HI;
                end
            end
            CHK_LO: begin
                if (s2) begin
                    state_nxt = HI;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = LO;
                    w_nxt     = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    state_nxt = CHK_LO;
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            default: state_nxt = LO;
        endcase
    end

    assign stout = state;
endmodule

// File: tb/tb_bit_conditioner.sv
// Randomised scoreboard bench for bit_conditioner: run-length reference model vs DUT, checked every cycle.
module tb_bit_conditioner;
    localparam int DB = 4;

    typedef struct {
        logic       w;
        logic       rise;
        logic       fall;
        logic [1:0] st;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pin = 1'b0;
    logic       w, w_rise, w_fall;
    logic [1:0] stout;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    // Reference model: pin reaches the debouncer two edges late; w flips once DB+1 consecutive
    // synchronised samples disagree with it, and any agreeing sample restarts that run.
    logic m_d1 = 1'b0, m_d2 = 1'b0, m_w = 1'b0;
    int   m_run = 0;

    bit_conditioner #(.DB_CYCLES(DB)) dut (
        .clk    (clk),
        .rst    (rst),
        .pin    (pin),
        .w      (w),
        .w_rise (w_rise),
        .w_fall (w_fall),
        .stout  (stout)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic p);
        exp_t e;
        logic samp;
        @(negedge clk);
        rst = r;
        pin = p;
        e.rise = 1'b0;
        e.fall = 1'b0;
        if (r) begin
            m_d1 = 1'b0; m_d2 = 1'b0; m_w = 1'b0; m_run = 0;
        end else begin
            samp = m_d2;
            m_d2 = m_d1;
            m_d1 = p;
            if (samp != m_w) begin
                m_run++;
                if (m_run == DB + 1) begin
                    m_w    = samp;
                    e.rise = samp;
                    e.fall = ~samp;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        e.w  = m_w;
        e.st = {m_w, (m_run > 0) ? 1'b1 : 1'b0};
        q.push_back(e);
    endtask

    task automatic hold(input logic p, input int n);
        for (int i = 0; i < n; i++) step(1'b0, p);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (w !== e.w || w_rise !== e.rise || w_fall !== e.fall || stout !== e.st) begin
                    failures++;
                    $display("FAIL out @%0t: got w=%b rise=%b fall=%b stout=%b, want w=%b rise=%b fall=%b stout=%b",
                             $time, w, w_rise, w_fall, stout, e.w, e.rise, e.fall, e.st);
                end
            end
        end
    end

    initial begin : driver
        int lvl;
        // reset held with a toggling pin
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
        hold(1'b0, 6);
        // clean rise, then fall from HI
        hold(1'b1, 12);
        hold(1'b0, 12);
        // bounce shorter than the debounce window
        hold(1'b1, 3); hold(1'b0, 1); hold(1'b1, 2); hold(1'b0, 10);
        // reset mid-count with pin still high, then full latency again
        hold(1'b1, 4);
        step(1'b1, 1'b1);
        hold(1'b1, 12);
        hold(1'b0, 12);
        // random level runs straddling the window, with occasional resets
        lvl = 0;
        for (int seg = 0; seg < 300; seg++) begin
            lvl = ~lvl & 1;
            if ($urandom_range(0, 39) == 0) step(1'b1, 1'(lvl));
            hold(1'(lvl), int'($urandom_range(1, 9)));
        end
        hold(1'b0, 12);
        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
